btn_conditioner: RTL
====================

# btn_conditioner

Front-end conditioner for the four pet-control pushbuttons (jugar, alimentar, test, reset). It synchronizes and debounces each raw board input and emits clean one-cycle press pulses. It also detects the 5 s long-press gestures that request test mode and a game reset. It sits directly upstream of `measures`: its pulses and levels replace the raw `jugar`/`alimentar`/`test`/`reset` pins that `measures` registers today.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency in Hz.
- `DEBOUNCE_MS`, 20: time a raw level must be stable before it is accepted.
- `LONG_MS`, 5000: hold time that qualifies as a long press.
- `ACTIVE_LOW`, 1: 1 means a button reads 0 when pressed; 0 means it reads 1 when pressed.

Derived constants:
- `DB_CYC` = CLK_HZ/1000*DEBOUNCE_MS.
- `LONG_CYC` = CLK_HZ/1000*LONG_MS.
- Counter width = $clog2(LONG_CYC+1).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `jugar`  in  1  raw play button, asynchronous.
- `alimentar`  in  1  raw feed button, asynchronous.
- `test`  in  1  raw test button, asynchronous.
- `reset`  in  1  raw game-reset button, asynchronous.
- `jugar_p`  out  1  one-cycle pulse per accepted play press.
- `alimentar_p`  out  1  one-cycle pulse per accepted feed press.
- `test_p`  out  1  one-cycle pulse per accepted test press (short or long).
- `test_mode`  out  1  level; toggles on each test long press.
- `reset_req`  out  1  one-cycle pulse when the reset button has been held for LONG_CYC.
- `pressed`  out  4  debounced levels, bit order {reset, test, alimentar, jugar}; 1 means pressed.

## Operation
- Each of the four buttons has an independent, identical channel. Channels share no state.
- Input stage: a 2-FF synchronizer, then polarity normalization (invert when ACTIVE_LOW=1), giving `s` with 1 = pressed.
- Per-channel FSM with states IDLE, DB_PRESS, HELD, DB_REL, plus a counter `cnt`:
  - IDLE (pressed=0): if s=1, go to DB_PRESS with cnt=1.
  - DB_PRESS:
    - If s=0, return to IDLE with cnt=0. A bounce restarts qualification.
    - Else if cnt==DB_CYC-1, go to HELD, set pressed=1, pulse the press output, and set cnt=0.
    - Else increment cnt.
  - HELD: cnt increments and saturates at LONG_CYC.
    - When cnt reaches LONG_CYC-1 (long channels only: test, reset), fire the long action once and clamp cnt at LONG_CYC so the action never repeats.
    - If s=0, go to DB_REL with cnt=1. The long counter is discarded.
  - DB_REL:
    - If s=1, return to HELD with cnt restarted at 0. The long hold restarts; a bounced release never yields a second press pulse.
    - If cnt==DB_CYC-1, go to IDLE with pressed=0.
- Long actions:
  - test channel: toggles `test_mode`.
  - reset channel: pulses `reset_req`.
  - jugar and alimentar have no long action.
- The reset channel never pulses a short-press output. Only `reset_req` and `pressed[3]` reflect it.
- Simultaneous presses on different channels each produce their own pulse, possibly in the same cycle.

## Timing
- Reset values: all FSMs IDLE, all counters 0, synchronizer FFs at the released level, `pressed`=0, all pulses 0, `test_mode`=0.
- Press latency: the pulse rises 2 (sync) + DB_CYC cycles after the first clean pressed sample reaches the pins. It is high for exactly 1 cycle, registered.
- Long latency: `reset_req` or the `test_mode` edge occurs LONG_CYC cycles after the press pulse.
- Release: `pressed` falls 2 + DB_CYC cycles after a clean release.
- `rst` asserted mid-operation: all state returns to reset values on the next edge, and any pulse in that cycle is suppressed. A button held through reset is re-qualified as a new press (press pulse after 2+DB_CYC cycles once `rst` deasserts).
- Minimum spacing between two accepted presses on one channel: 2*DB_CYC cycles.

## Test plan
Bench runs with CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=20, so DB_CYC=4 and LONG_CYC=20.
- Clean press of `jugar` (low for 30 cycles, ACTIVE_LOW=1) -> exactly one `jugar_p` at cycle 6 after the falling input; `pressed[0]` high from cycle 6 until 6 cycles after release.
- `alimentar` bounce pattern 1,0,1,0 one cycle each, then stable 0 -> no pulse during the bounce; one `alimentar_p` 6 cycles after the final stable edge.
- `test` held 40 cycles -> `test_p` at cycle 6, `test_mode` goes 0→1 at cycle 26 and stays 1; a second identical hold -> back to 0.
- `reset` held 15 cycles -> no `reset_req`. `reset` held 40 cycles -> exactly one `reset_req` at cycle 26.
- `jugar` and `alimentar` pressed in the same cycle -> both pulses in the same cycle.
- `rst` asserted at cycle 10 of a `test` hold -> `test_mode`=0 and `pressed`=0. After deassert, `test_p` fires again 6 cycles later and the long toggle occurs 20 cycles after that pulse.

Source files
------------

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - debounced press pulses and long-press gestures for the four pet buttons
//
// btn_channel: one button. It has a 2-FF synchronizer, polarity normalization,
// and a debounce/long-press FSM.
//   clk, rst   : clock, synchronous active-high reset
//   raw_i      : asynchronous raw button level
//   pressed_o  : debounced level, 1 = pressed
//   press_p_o  : one-cycle pulse per accepted press (when HAS_SHORT)
//   long_o     : long-press action (LONG_MODE 0 none, 1 pulse, 2 toggled level)
//
// btn_conditioner: four independent channels {reset, test, alimentar, jugar}.
//   jugar, alimentar, test, reset : raw asynchronous buttons
//   jugar_p, alimentar_p, test_p  : press pulses
//   test_mode : level, toggles on each long test press
//   reset_req : pulse on each long reset press
//   pressed   : debounced levels {reset, test, alimentar, jugar}

module btn_channel #(
  parameter int unsigned DB_CYC     = 4,
  parameter int unsigned LONG_CYC   = 20,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          HAS_SHORT  = 1'b1,
  parameter int unsigned LONG_MODE  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic pressed_o,
  output logic press_p_o,
  output logic long_o
);

  localparam int unsigned   CW        = $clog2(LONG_CYC + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYC);
  localparam logic          RELEASED  = ACTIVE_LOW;

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          sync1_q;
  logic          sync2_q;
  logic          pressed_q;
  logic          press_p_q;
  logic          long_q;
  logic          s;

  // s is 1 while the synchronized button is pressed, whatever the board polarity.
  assign s = sync2_q ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= RELEASED;
      sync2_q   <= RELEASED;
      state_q   <= IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_p_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      press_p_q <= 1'b0;
      if (LONG_MODE == 1) long_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s) begin
            state_q <= DB_PRESS;
            cnt_q   <= CW'(1);
          end
        end
        DB_PRESS: begin
          if (!s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= HELD;
            pressed_q <= 1'b1;
            press_p_q <= HAS_SHORT;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HELD: begin
          // A release sample takes priority over the long action.
          if (!s) begin
            state_q <= DB_REL;
            cnt_q   <= CW'(1);
          end else if (cnt_q == LONG_LAST) begin
            // Parking at LONG_SAT keeps the action from firing again.
            cnt_q <= LONG_SAT;
            if (LONG_MODE == 1) long_q <= 1'b1;
            else if (LONG_MODE == 2) long_q <= ~long_q;
          end else if (cnt_q != LONG_SAT) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DB_REL: begin
          // A bounced release goes back to HELD without a new press pulse,
          // but the long hold starts over.
          if (s) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= IDLE;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pressed_o = pressed_q;
  assign press_p_o = press_p_q;
  assign long_o    = long_q;

endmodule

module btn_conditioner #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 5000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       jugar,
  input  logic       alimentar,
  input  logic       test,
  input  logic       reset,
  output logic       jugar_p,
  output logic       alimentar_p,
  output logic       test_p,
  output logic       test_mode,
  output logic       reset_req,
  output logic [3:0] pressed
);

  localparam int unsigned DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned LONG_CYC = CLK_HZ / 1000 * LONG_MS;

  logic jugar_long;
  logic alim_long;
  logic reset_press_p;
  logic unused_ch;

  btn_channel #(
    .DB_CYC(DB_CYC), .LONG_CYC(LONG_CYC), .ACTIVE_LOW(ACTIVE_LOW),
    .HAS_SHORT(1'b1), .LONG_MODE(0)
  ) u_jugar (
    .clk(clk), .rst(rst), .raw_i(jugar),
    .pressed_o(pressed[0]), .press_p_o(jugar_p), .long_o(jugar_long)
  );

  btn_channel #(
    .DB_CYC(DB_CYC), .LONG_CYC(LONG_CYC), .ACTIVE_LOW(ACTIVE_LOW),
    .HAS_SHORT(1'b1), .LONG_MODE(0)
  ) u_alimentar (
    .clk(clk), .rst(rst), .raw_i(alimentar),
    .pressed_o(pressed[1]), .press_p_o(alimentar_p), .long_o(alim_long)
  );

  btn_channel #(
    .DB_CYC(DB_CYC), .LONG_CYC(LONG_CYC), .ACTIVE_LOW(ACTIVE_LOW),
    .HAS_SHORT(1'b1), .LONG_MODE(2)
  ) u_test (
    .clk(clk), .rst(rst), .raw_i(test),
    .pressed_o(pressed[2]), .press_p_o(test_p), .long_o(test_mode)
  );

  // The game-reset button never produces a short-press pulse.
  btn_channel #(
    .DB_CYC(DB_CYC), .LONG_CYC(LONG_CYC), .ACTIVE_LOW(ACTIVE_LOW),
    .HAS_SHORT(1'b0), .LONG_MODE(1)
  ) u_reset (
    .clk(clk), .rst(rst), .raw_i(reset),
    .pressed_o(pressed[3]), .press_p_o(reset_press_p), .long_o(reset_req)
  );

  // These channel outputs are constant 0 for these channels.
  assign unused_ch = ^{jugar_long, alim_long, reset_press_p};

endmodule
